// File: rtl/pwm_pkg.sv
// pwm_pkg: mode/direction encodings and duty-field packing helper shared by the PWM block
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Low bit of channel k's duty field; each field is r+1 bits so that 100% duty fits.
    function automatic int duty_lo(input int k, input int r);
        return k * (r + 1);
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: divides clk into a counter tick every prescale+1 cycles
module pwm_prescaler #(
    parameter int PRE_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [PRE_W-1:0] prescale,
    output logic             tick
);

    logic [PRE_W-1:0] pre_cnt;

    // Using >= lets a prescale reduction below the current count fire immediately and restart at 0.
    assign tick = enable && (pre_cnt >= prescale);

    // Count up to the divisor, restart on tick; hold at 0 while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pre_cnt <= '0;
        else
            pre_cnt <= (!enable || tick) ? '0 : pre_cnt + 1'b1;
    end

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: CH-channel PWM with shared period counter, prescaler, edge/center modes and double-buffered updates
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int CH    = 4,
    parameter int R     = 8,
    parameter int PRE_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [PRE_W-1:0]      prescale,
    input  logic                  center,
    input  logic [R-1:0]          period,
    input  logic [CH*(R+1)-1:0]   duty,
    input  logic                  load,
    output logic [CH-1:0]         pwm_out,
    output logic                  period_tick,
    output logic                  load_pending
);

    localparam int DW = CH * (R + 1);

    logic          tick;
    logic          wrap;
    logic          dir;
    logic          mode;
    logic [R-1:0]  cnt;
    logic [R-1:0]  cnt_inc;
    logic [R-1:0]  p_act;
    logic [R-1:0]  p_stg;
    logic [DW-1:0] d_act;
    logic [DW-1:0] d_stg;
    logic [CH-1:0] hit;

    pwm_prescaler #(.PRE_W(PRE_W)) u_pre (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .prescale (prescale),
        .tick     (tick)
    );

    // Wrap tick: last tick of the period (cnt==P in edge mode, cnt==1 on the way down in center mode).
    always_comb begin
        cnt_inc = cnt + 1'b1;
        wrap    = tick && ((mode == MODE_EDGE) ? (cnt == p_act)
                                               : (p_act == '0 || (cnt == R'(1) && dir == DIR_DOWN)));
    end

    // Period counter; every wrap restarts at 0 counting up, so a new period or mode never sees a stale count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            dir <= DIR_UP;
        end else if (!enable || wrap) begin
            cnt <= '0;
            dir <= DIR_UP;
        end else if (tick) begin
            if (mode == MODE_EDGE) begin
                cnt <= cnt_inc;
            end else if (dir == DIR_UP) begin
                cnt <= cnt_inc;
                dir <= (cnt_inc == p_act) ? DIR_DOWN : DIR_UP;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Shadow registers: loads stage, wraps commit; a load coinciding with a wrap bypasses staging.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_stg        <= '0;
            d_stg        <= '0;
            p_act        <= '0;
            d_act        <= '0;
            mode         <= MODE_EDGE;
            load_pending <= 1'b0;
        end else begin
            if (load) begin
                p_stg <= period;
                d_stg <= duty;
            end
            if (wrap) begin
                mode <= center;
                if (load || load_pending) begin
                    p_act <= load ? period : p_stg;
                    d_act <= load ? duty : d_stg;
                end
            end
            load_pending <= wrap ? 1'b0 : (load_pending | load);
        end
    end

    // Per-channel compare of the zero-extended count against the active duty.
    for (genvar k = 0; k < CH; k++) begin : g_cmp
        localparam int LO = duty_lo(k, R);
        assign hit[k] = {1'b0, cnt} < d_act[LO +: R+1];
    end

    // Outputs follow the compare on each tick, forced low while disabled; period_tick delays the wrap by one clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_out     <= '0;
            period_tick <= 1'b0;
        end else begin
            period_tick <= wrap;
            pwm_out     <= !enable ? '0 : (tick ? hit : pwm_out);
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: table-driven period/duty measurements, corner sequences and a randomized reference-model run
module tb_pwm_multi;

    localparam int CH    = 2;
    localparam int R     = 8;
    localparam int PRE_W = 16;
    localparam int DWID  = R + 1;
    localparam int DW    = CH * DWID;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [PRE_W-1:0] prescale;
    logic             center;
    logic [R-1:0]     period;
    logic [DW-1:0]    duty;
    logic             load;
    logic [CH-1:0]    pwm_out;
    logic             period_tick;
    logic             load_pending;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pwm_multi #(.CH(CH), .R(R), .PRE_W(PRE_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .prescale     (prescale),
        .center       (center),
        .period       (period),
        .duty         (duty),
        .load         (load),
        .pwm_out      (pwm_out),
        .period_tick  (period_tick),
        .load_pending (load_pending)
    );

    typedef struct {
        int ps; int p; int d0; int d1; bit c;
        int len; int h0; int h1;
    } vec_t;

    vec_t tv[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pack(input int a, input int b);
        return {DWID'(b), DWID'(a)};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        load  = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_pt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (period_tick) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL timeout: no period_tick within 3000 clk");
        end
    endtask

    // Samples one full period: from just after a period_tick up to and including the next one.
    task automatic count_window(output int len, output int h0, output int h1);
        len = 0; h0 = 0; h1 = 0;
        do begin
            @(posedge clk);
            #1;
            len++;
            h0 += int'(pwm_out[0]);
            h1 += int'(pwm_out[1]);
        end while (!period_tick && len < 3000);
    endtask

    task automatic measure(output int len, output int h0, output int h1);
        bit ok;
        for (int i = 0; i < 3; i++) wait_pt(ok);
        count_window(len, h0, h1);
    endtask

    // Reference model: position within the period, with the count derived from the period shape.
    int m_pc, m_ph, m_P, m_mode, s_P, m_pend, m_tick;
    int m_D[CH];
    int s_D[CH];
    int m_out[CH];

    task automatic model_reset();
        m_pc = 0; m_ph = 0; m_P = 0; m_mode = 0; s_P = 0; m_pend = 0; m_tick = 0;
        for (int k = 0; k < CH; k++) begin
            m_D[k] = 0; s_D[k] = 0; m_out[k] = 0;
        end
    endtask

    task automatic model_step();
        int tk, len, c, w;
        tk = (enable && m_pc >= int'(prescale)) ? 1 : 0;
        m_pc = (!enable || tk != 0) ? 0 : m_pc + 1;
        w = 0;
        if (!enable) begin
            m_ph = 0;
            for (int k = 0; k < CH; k++) m_out[k] = 0;
        end else if (tk != 0) begin
            len = (m_mode != 0) ? ((m_P == 0) ? 1 : 2 * m_P) : m_P + 1;
            c = (m_mode == 0 || m_ph <= m_P) ? m_ph : 2 * m_P - m_ph;
            w = (m_ph == len - 1) ? 1 : 0;
            for (int k = 0; k < CH; k++) m_out[k] = (c < m_D[k]) ? 1 : 0;
            m_ph = (w != 0) ? 0 : m_ph + 1;
        end
        m_tick = w;
        if (w != 0) begin
            m_mode = int'(center);
            if (load) begin
                m_P = int'(period);
                for (int k = 0; k < CH; k++) m_D[k] = int'(duty[k*DWID +: DWID]);
            end else if (m_pend != 0) begin
                m_P = s_P;
                for (int k = 0; k < CH; k++) m_D[k] = s_D[k];
            end
            m_pend = 0;
        end else if (load) begin
            s_P = int'(period);
            for (int k = 0; k < CH; k++) s_D[k] = int'(duty[k*DWID +: DWID]);
            m_pend = 1;
        end
    endtask

    initial begin
        int len, h0, h1, n;
        bit ok;
        logic [CH+1:0] ev, av;

        tv[0] = '{0, 9,   3,   7,   0, 10,  3,   7};
        tv[1] = '{0, 9,   0,   10,  0, 10,  0,   10};
        tv[2] = '{3, 4,   2,   0,   1, 32,  12,  0};
        tv[3] = '{0, 4,   5,   4,   1, 8,   8,   7};
        tv[4] = '{1, 5,   1,   6,   0, 12,  2,   12};
        tv[5] = '{0, 0,   1,   0,   1, 1,   1,   0};
        tv[6] = '{2, 1,   1,   2,   1, 6,   3,   6};
        tv[7] = '{0, 255, 256, 128, 0, 256, 256, 128};

        enable = 1'b0; prescale = '0; center = 1'b0; period = '0; duty = '0; load = 1'b0;
        reset = 1'b1;
        #1;
        check("reset_pwm", 32'(pwm_out), 0);
        check("reset_tick", 32'(period_tick), 0);
        check("reset_pend", 32'(load_pending), 0);
        do_reset();

        for (int i = 0; i < 8; i++) begin
            do_reset();
            prescale = PRE_W'(tv[i].ps);
            center   = tv[i].c;
            period   = R'(tv[i].p);
            duty     = pack(tv[i].d0, tv[i].d1);
            enable   = 1'b1;
            load     = 1'b1;
            @(posedge clk);
            #1 load = 1'b0;
            measure(len, h0, h1);
            check($sformatf("vec%0d_len", i), 32'(len), 32'(tv[i].len));
            check($sformatf("vec%0d_h0", i), 32'(h0), 32'(tv[i].h0));
            check($sformatf("vec%0d_h1", i), 32'(h1), 32'(tv[i].h1));
        end

        do_reset();
        prescale = '0; center = 1'b0; period = 8'd9; duty = pack(3, 7); enable = 1'b1; load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        wait_pt(ok);
        wait_pt(ok);
        len = 0; h0 = 0;
        do begin
            if (len == 4) begin
                duty = pack(6, 7);
                load = 1'b1;
            end
            @(posedge clk);
            #1 load = 1'b0;
            len++;
            h0 += int'(pwm_out[0]);
            if (len == 5) check("pend_set", 32'(load_pending), 1);
        end while (!period_tick && len < 100);
        check("shadow_old_len", 32'(len), 10);
        check("shadow_old_high", 32'(h0), 3);
        check("pend_clr", 32'(load_pending), 0);
        count_window(len, h0, h1);
        check("shadow_new_high", 32'(h0), 6);

        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
        end
        duty = pack(2, 7);
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        check("wrapload_tick", 32'(period_tick), 1);
        check("wrapload_pend", 32'(load_pending), 0);
        count_window(len, h0, h1);
        check("wrapload_high", 32'(h0), 2);

        repeat (4) begin
            @(posedge clk);
            #1;
        end
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("dis_pwm", 32'(pwm_out), 0);
        check("dis_tick", 32'(period_tick), 0);
        repeat (3) @(posedge clk);
        #1;
        check("dis_hold", 32'(pwm_out), 0);
        enable = 1'b1;
        @(posedge clk);
        #1 check("resume_c0", 32'(pwm_out[0]), 1);
        @(posedge clk);
        #1 check("resume_c1", 32'(pwm_out[0]), 1);
        @(posedge clk);
        #1 check("resume_c2", 32'(pwm_out[0]), 0);
        n = 3;
        while (!period_tick && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        check("resume_len", 32'(n), 10);

        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (pwm_out[0]) break;
        end
        #2 reset = 1'b1;
        #1;
        check("async_rst_pwm", 32'(pwm_out), 0);
        check("async_rst_pend", 32'(load_pending), 0);
        #3 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_pwm", 32'(pwm_out), 0);
        check("post_rst_tick", 32'(period_tick), 1);

        enable = 1'b0; prescale = '0; center = 1'b0; period = '0; duty = '0;
        do_reset();
        model_reset();
        for (int i = 0; i < 4000; i++) begin
            load = ($urandom_range(0, 7) == 0);
            period = R'($urandom_range(0, 10));
            duty = pack($urandom_range(0, 12), $urandom_range(0, 12));
            if ($urandom_range(0, 29) == 0) center = ~center;
            if ($urandom_range(0, 99) == 0) prescale = PRE_W'($urandom_range(0, 3));
            enable = ($urandom_range(0, 39) != 0);
            @(posedge clk);
            model_step();
            #1;
            for (int k = 0; k < CH; k++) ev[k+2] = (m_out[k] != 0);
            ev[1] = (m_tick != 0);
            ev[0] = (m_pend != 0);
            av = {pwm_out, period_tick, load_pending};
            check($sformatf("model_cyc%0d", i), 32'(av), 32'(ev));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
